bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_if.sv | 36 +++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter and its digit cells.
// State codes, add-3 threshold and the counter width helper.
package bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] ADJ_VALUE     = 4'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/ready/done bundle between a value source and the converter.
// The master side drives start and bin_in; the slave side answers.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);

  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start,
    output bin_in,
    input  ready,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output ready,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Add-3 correction cell for one BCD nibble ahead of a left shift.
// Shared with the multi-digit display driver.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= ADJ_THRESHOLD) ? digit + ADJ_VALUE : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock.
// Result registers update only on DONE so the decoders never glitch.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input logic            clk,
  input logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = clog2(BIN_WIDTH);

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [BW-1:0]        work;
  logic [BW-1:0]        adj;
  logic [CW-1:0]        cnt;
  logic                 acc;
  logic [BW-1:0]        bcd_q;
  logic                 ovf_q;
  logic                 done_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work[4*i +: 4]),
      .adj   (adj[4*i +: 4])
    );
  end

  // Carry out of the top digit is a lost multiple of 10^DIGITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      work   <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg <= bus.bin_in;
            work  <= '0;
            acc   <= 1'b0;
            cnt   <= CW'(BIN_WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          work  <= {adj[BW-2:0], shreg[BIN_WIDTH-1]};
          acc   <= acc | adj[BW-1];
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          bcd_q <= work;
          ovf_q <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed cases, full sweep, random values,
// and a two-digit instance for the overflow path.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  bin_to_bcd_seq_if #(.BIN_WIDTH(8), .DIGITS(3)) a_if ();
  bin_to_bcd_seq_if #(.BIN_WIDTH(8), .DIGITS(2)) b_if ();

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      r = r | (32'((v / p) % 10) << (4 * k));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int nd);
    return v >= 10 ** nd;
  endfunction

  // Start one conversion on a_if; lat counts edges after acceptance.
  task automatic conv_a(input int v, output int lat, output int bc);
    @(negedge clk);
    a_if.start  = 1'b1;
    a_if.bin_in = 8'(v);
    @(posedge clk);
    #1;
    a_if.start  = 1'b0;
    a_if.bin_in = 8'($urandom);
    lat = 0;
    bc  = int'(a_if.busy);
    while (!a_if.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      bc += int'(a_if.busy);
    end
  endtask

  task automatic check_a(input string tag, input int v);
    int lat, bc;
    conv_a(v, lat, bc);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_bcd"}, a_if.bcd_out, ref_bcd(v, 3));
    chk({tag, "_ovf"}, a_if.overflow, ref_ovf(v, 3));
  endtask

  task automatic check_b(input string tag, input int v);
    int k;
    @(negedge clk);
    b_if.start  = 1'b1;
    b_if.bin_in = 8'(v);
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    k = 0;
    while (!b_if.done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_lat"}, k, 9);
    chk({tag, "_bcd"}, b_if.bcd_out, ref_bcd(v % 100, 2));
    chk({tag, "_ovf"}, b_if.overflow, ref_ovf(v, 2));
  endtask

  initial begin
    int lat, bc, k, prev, seen, v;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    a_if.start  = 1'b0;
    a_if.bin_in = '0;
    b_if.start  = 1'b0;
    b_if.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_if.ready, 1);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_bcd", a_if.bcd_out, 0);
    chk("rst_ovf", a_if.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero input, single-cycle done, ready back with it
    conv_a(0, lat, bc);
    chk("zero_lat", lat, 9);
    chk("zero_bcd", a_if.bcd_out, 0);
    chk("zero_ovf", a_if.overflow, 0);
    chk("zero_ready", a_if.ready, 1);
    @(posedge clk);
    #1;
    chk("zero_done_pulse", a_if.done, 0);

    // all ones, busy span
    conv_a(255, lat, bc);
    chk("max_lat", lat, 9);
    chk("max_busy_cycles", bc, 8);
    chk("max_bcd", a_if.bcd_out, ref_bcd(255, 3));
    chk("max_ovf", a_if.overflow, 0);

    // start and bin_in changes during SHIFT are ignored
    @(negedge clk);
    a_if.start  = 1'b1;
    a_if.bin_in = 8'd99;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_if.start  = 1'b1;
    a_if.bin_in = 8'd42;
    @(posedge clk);
    #1;
    a_if.start  = 1'b0;
    a_if.bin_in = 8'd13;
    k = 3;
    while (!a_if.done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ign_lat", k, 9);
    chk("ign_bcd", a_if.bcd_out, 32'h099);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen += int'(a_if.done);
    end
    chk("ign_no_second_done", seen, 0);

    // reset during SHIFT aborts with no done pulse
    @(negedge clk);
    a_if.start  = 1'b1;
    a_if.bin_in = 8'd200;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", a_if.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", a_if.bcd_out, 0);
    chk("abort_ovf", a_if.overflow, 0);
    chk("abort_busy", a_if.busy, 0);
    chk("abort_ready", a_if.ready, 1);
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen += int'(a_if.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen += int'(a_if.done);
    end
    chk("abort_no_done", seen, 0);
    check_a("after_abort", 7);

    // sweep with start held high: one result every 10 cycles
    a_if.start = 1'b1;
    prev = 0;
    for (int s = 0; s < 256; s++) begin
      k = 0;
      @(negedge clk);
      while (!a_if.ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      a_if.bin_in = 8'(s);
      @(posedge clk);
      #1;
      k = 0;
      while (!a_if.done && k < 20) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("sweep_bcd", a_if.bcd_out, ref_bcd(s, 3));
      chk("sweep_ovf", a_if.overflow, 0);
      if (s > 0) chk("sweep_period", cyc - prev, 10);
      prev = cyc;
    end
    a_if.start = 1'b0;
    repeat (3) @(posedge clk);

    // random values with random idle gaps
    for (int r = 0; r < 40; r++) begin
      v = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      check_a("rand_a", v);
    end

    // two-digit instance: truncation and overflow
    check_b("d2_255", 255);
    chk("d2_255_exact", b_if.bcd_out, 32'h55);
    check_b("d2_12", 12);
    for (int r = 0; r < 20; r++) begin
      v = int'($urandom_range(0, 255));
      check_b("rand_b", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
